alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Integer execution unit directly downstream of the reservation station. Accepts one dispatched op per handshake (rs_valid_out/alu_ready), computes single-cycle ALU ops or a multi-cycle multiply, and holds results in a small FIFO. The FIFO requests the common data bus (CDB) arbiter; on grant, the head result's tag and data are broadcast to the reservation stations and register status.

Parameters:
MUL_LAT, 4, cycles a MULT occupies the unit from accept to result push (legal 2..15)
BUF_DEPTH, 2, result FIFO entries (legal 2, 4, 8)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rs_valid_out  input  1  reservation station has a ready op
alu_opcode  input  6  operation code
alu_op1  input  32  operand 1 (rs value)
alu_op2  input  32  operand 2 (rt value)
alu_dest_tag  input  5  destination tag
alu_ready  output  1  unit can accept an op this cycle
cdb_req  output  1  FIFO non-empty, requesting CDB
cdb_grant  input  1  arbiter grants CDB to this unit this cycle
cdb_tag  output  5  head entry tag (valid when cdb_req)
cdb_data  output  32  head entry result (valid when cdb_req)
busy  output  1  multiply in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, mul counter=0, FIFO count/pointers=0. alu_ready=0 while rst_n=0, then 1 from the first cycle after release. cdb_req=0, cdb_tag=0, cdb_data=0, busy=0.
- Accept: on a rising edge with rs_valid_out=1 and alu_ready=1. No other input is sampled.
- alu_ready = (state==IDLE) && (count<BUF_DEPTH). It is driven from registers only and has no combinational path from cdb_grant or rs_valid_out.
- Opcodes (hex):
  - 20 ADD: op1+op2 mod 2^32, no overflow trap.
  - 22 SUB: op1-op2.
  - 24 AND.
  - 25 OR.
  - 26 XOR.
  - 27 NOR.
  - 2A SLT: signed compare, result 1 or 0.
  - 2B SLTU: unsigned compare.
  - 00 SLL: op1<<op2[4:0].
  - 02 SRL: logical right shift.
  - 03 SRA: arithmetic right shift.
  - 18 MULT: low 32 bits of the signed 32x32 product.
  - Any other opcode: result 0, still broadcast so the tag retires.
- Single-cycle ops: the result and tag are pushed into the FIFO at the accept edge. cdb_req is high in the following cycle (1-cycle latency).
- MULT state machine:
  - IDLE -> MUL_BUSY at the accept edge. Operands and tag are latched, counter=MUL_LAT-1, busy=1.
  - In MUL_BUSY the counter decrements each edge. At the edge where the counter is 0, the product is pushed and the state returns to IDLE.
  - Push happens MUL_LAT edges after accept. alu_ready=0 throughout MUL_BUSY.
  - A back-to-back accept is possible at the edge after the return to IDLE.
- FIFO ordering: entries leave in push order.
- FIFO output: cdb_tag/cdb_data present the head entry. They hold their value when cdb_req=0.
- Pop: at an edge with cdb_req=1 and cdb_grant=1. cdb_grant while cdb_req=0 is ignored.
- Simultaneous push and pop: both occur and count is unchanged. A pop at the same edge as a push into an empty FIFO cannot happen, because cdb_req was 0.
- Full FIFO: alu_ready drops. The unit never pushes into a full FIFO. Space for a MULT result is guaranteed because MULT is accepted only when count<BUF_DEPTH and nothing else pushes during MUL_BUSY.
- Pointers wrap modulo BUF_DEPTH.
- Reset mid-multiply or with a non-empty FIFO: all in-flight results are discarded immediately, with no broadcast.

Test Plan:
- Reset release, cdb_grant held 1; ADD op1=5 op2=7 tag=3 accepted at edge E -> cycle after E: cdb_req=1, cdb_tag=3, cdb_data=12; popped at E+1, then cdb_req=0.
- SUB 0-1 -> cdb_data=FFFFFFFF. SLT op1=FFFFFFFF op2=1 -> 1. SLTU with the same operands -> 0. SRA op1=80000000 op2=4 -> F8000000. Opcode 3F tag=9 -> cdb_data=0, tag 9 broadcast.
- MULT op1=FFFFFFFE op2=3 tag=7, MUL_LAT=4, grant=1 -> busy=1 and alu_ready=0 for 4 cycles; cdb_req rises the cycle after the 4th edge with data=FFFFFFFA, tag=7.
- cdb_grant=0, issue ADD tags 1 and 2 back-to-back -> alu_ready=0 after the second accept (count=2), rs_valid_out ignored. Set grant=1 -> broadcasts in order tag1 then tag2, and alu_ready=1 after the first pop.
- FIFO holds 1 entry, grant=1, new ADD accepted on the same edge -> count stays 1 and the next cycle shows the new tag.
- Assert rst_n=0 during MUL_BUSY with 1 entry buffered -> cdb_req=0 and busy=0 immediately (asynchronously); after release nothing is broadcast and alu_ready=1.

Source files
------------

// File: rtl/alu_exec_if.sv
// Dispatch and CDB handshake bundle between the reservation station, the
// integer execution unit and the CDB arbiter.
interface alu_exec_if;
    logic        rs_valid_out;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [4:0]  alu_dest_tag;
    logic        alu_ready;
    logic        cdb_req;
    logic        cdb_grant;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        busy;

    modport master (
        output rs_valid_out, alu_opcode, alu_op1, alu_op2, alu_dest_tag, cdb_grant,
        input  alu_ready, cdb_req, cdb_tag, cdb_data, busy
    );

    modport slave (
        input  rs_valid_out, alu_opcode, alu_op1, alu_op2, alu_dest_tag, cdb_grant,
        output alu_ready, cdb_req, cdb_tag, cdb_data, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle ALU ops, multi-cycle MULT, and a small
// result FIFO that requests the CDB and broadcasts its head entry on grant.
module alu_exec_unit #(
    parameter int MUL_LAT   = 4,
    parameter int BUF_DEPTH = 2
) (
    input logic       clk,
    input logic       rst_n,
    alu_exec_if.slave bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [5:0] OP_MULT = 6'h18;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t             state_q, state_d;
    logic [3:0]         mul_cnt_q, mul_cnt_d;
    logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [4:0]         mul_tag_q, mul_tag_d;
    logic [4:0]         tag_mem_q  [BUF_DEPTH];
    logic [4:0]         tag_mem_d  [BUF_DEPTH];
    logic [31:0]        data_mem_q [BUF_DEPTH];
    logic [31:0]        data_mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               alu_ready_q, alu_ready_d;
    logic               cdb_req_q, cdb_req_d;
    logic [4:0]         cdb_tag_q, cdb_tag_d;
    logic [31:0]        cdb_data_q, cdb_data_d;
    logic               busy_q, busy_d;

    logic               accept, pop, push;
    logic [4:0]         push_tag;
    logic [31:0]        push_data, alu_res;

    always_comb begin
        alu_res = 32'd0;
        case (bus.alu_opcode)
            6'h20: alu_res = bus.alu_op1 + bus.alu_op2;
            6'h22: alu_res = bus.alu_op1 - bus.alu_op2;
            6'h24: alu_res = bus.alu_op1 & bus.alu_op2;
            6'h25: alu_res = bus.alu_op1 | bus.alu_op2;
            6'h26: alu_res = bus.alu_op1 ^ bus.alu_op2;
            6'h27: alu_res = ~(bus.alu_op1 | bus.alu_op2);
            6'h2A: alu_res = {31'd0, $signed(bus.alu_op1) < $signed(bus.alu_op2)};
            6'h2B: alu_res = {31'd0, bus.alu_op1 < bus.alu_op2};
            6'h00: alu_res = bus.alu_op1 << bus.alu_op2[4:0];
            6'h02: alu_res = bus.alu_op1 >> bus.alu_op2[4:0];
            6'h03: alu_res = $unsigned($signed(bus.alu_op1) >>> bus.alu_op2[4:0]);
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_tag_d  = mul_tag_q;
        tag_mem_d  = tag_mem_q;
        data_mem_d = data_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        push       = 1'b0;
        push_tag   = 5'd0;
        push_data  = 32'd0;
        accept     = bus.rs_valid_out && alu_ready_q;
        pop        = cdb_req_q && bus.cdb_grant;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.alu_opcode == OP_MULT) begin
                        state_d   = MUL_BUSY;
                        mul_cnt_d = 4'(MUL_LAT - 1);
                        mul_a_d   = bus.alu_op1;
                        mul_b_d   = bus.alu_op2;
                        mul_tag_d = bus.alu_dest_tag;
                    end else begin
                        push      = 1'b1;
                        push_tag  = bus.alu_dest_tag;
                        push_data = alu_res;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_cnt_q == 4'd0) begin
                    push      = 1'b1;
                    push_tag  = mul_tag_q;
                    // low word of the product is the same for signed and unsigned
                    push_data = mul_a_q * mul_b_q;
                    state_d   = IDLE;
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            tag_mem_d[wr_ptr_q]  = push_tag;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Next head is the entry being pushed when it lands straight at the head
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                cdb_tag_d  = push_tag;
                cdb_data_d = push_data;
            end else begin
                cdb_tag_d  = tag_mem_q[rd_ptr_d];
                cdb_data_d = data_mem_q[rd_ptr_d];
            end
        end

        cdb_req_d   = (count_d != '0);
        busy_d      = (state_d == MUL_BUSY);
        alu_ready_d = (state_d == IDLE) && (count_d < CNT_W'(BUF_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mul_cnt_q   <= 4'd0;
            mul_a_q     <= 32'd0;
            mul_b_q     <= 32'd0;
            mul_tag_q   <= 5'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                tag_mem_q[i]  <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            alu_ready_q <= 1'b0;
            cdb_req_q   <= 1'b0;
            cdb_tag_q   <= 5'd0;
            cdb_data_q  <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_tag_q   <= mul_tag_d;
            tag_mem_q   <= tag_mem_d;
            data_mem_q  <= data_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            alu_ready_q <= alu_ready_d;
            cdb_req_q   <= cdb_req_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.alu_ready = alu_ready_q;
    assign bus.cdb_req   = cdb_req_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus random traffic checked
// against a queue-based transaction model of the unit.
module tb_alu_exec_unit;
    localparam int MUL_LAT   = 4;
    localparam int BUF_DEPTH = 2;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ent_t        q[$];
    ent_t        mul_ent;
    int          mul_left = 0;
    bit          armed = 0;
    logic [4:0]  last_tag = 5'd0;
    logic [31:0] last_data = 32'd0;

    logic [5:0] ops [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h2B, 6'h00, 6'h02, 6'h03, 6'h18, 6'h3F, 6'h01};

    alu_exec_if bus ();

    alu_exec_unit #(.MUL_LAT(MUL_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int     sa, sb;
        longint la, lb;
        int     sh;
        sa = int'(a);
        sb = int'(b);
        la = longint'(sa);
        lb = longint'(sb);
        sh = int'(b & 32'd31);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h00: return a << sh;
            6'h02: return a >> sh;
            6'h03: return 32'(la >>> sh);
            6'h18: return 32'(la * lb);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a falling edge: drive, check the model, clock once, update model.
    task automatic cycle(input bit v, input logic [5:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input bit g);
        bit   exp_ready;
        ent_t e;
        bus.rs_valid_out = v;
        bus.alu_opcode   = opc;
        bus.alu_op1      = a;
        bus.alu_op2      = b;
        bus.alu_dest_tag = tag;
        bus.cdb_grant    = g;
        #1;
        exp_ready = armed && (mul_left == 0) && (q.size() < BUF_DEPTH);
        if (q.size() > 0) begin
            last_tag  = q[0].tag;
            last_data = q[0].data;
        end
        chk("alu_ready", 32'(bus.alu_ready), 32'(exp_ready));
        chk("busy", 32'(bus.busy), (mul_left > 0) ? 32'd1 : 32'd0);
        chk("cdb_req", 32'(bus.cdb_req), (q.size() > 0) ? 32'd1 : 32'd0);
        chk("cdb_tag", 32'(bus.cdb_tag), 32'(last_tag));
        chk("cdb_data", bus.cdb_data, last_data);
        @(posedge clk);
        if (q.size() > 0 && g) void'(q.pop_front());
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) q.push_back(mul_ent);
        end else if (v && exp_ready) begin
            e.tag  = tag;
            e.data = ref_op(opc, a, b);
            if (opc == 6'h18) begin
                mul_ent  = e;
                mul_left = MUL_LAT;
            end else begin
                q.push_back(e);
            end
        end
        armed = 1;
        @(negedge clk);
    endtask

    task automatic idle(input bit g);
        cycle(1'b0, 6'h20, 32'd0, 32'd0, 5'd0, g);
    endtask

    task automatic one_shot(input string name, input logic [5:0] opc, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag,
                            input logic [31:0] exp_data);
        cycle(1'b1, opc, a, b, tag, 1'b1);
        chk({name, "_req"}, 32'(bus.cdb_req), 32'd1);
        chk({name, "_tag"}, 32'(bus.cdb_tag), 32'(tag));
        chk({name, "_data"}, bus.cdb_data, exp_data);
        idle(1'b1);
    endtask

    initial begin
        bus.rs_valid_out = 1'b0;
        bus.alu_opcode   = 6'd0;
        bus.alu_op1      = 32'd0;
        bus.alu_op2      = 32'd0;
        bus.alu_dest_tag = 5'd0;
        bus.cdb_grant    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_req", 32'(bus.cdb_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", bus.cdb_data, 32'd0);
        rst_n = 1'b1;
        idle(1'b1);

        one_shot("add", 6'h20, 32'd5, 32'd7, 5'd3, 32'd12);
        chk("add_popped", 32'(bus.cdb_req), 32'd0);
        one_shot("sub", 6'h22, 32'd0, 32'd1, 5'd4, 32'hFFFF_FFFF);
        one_shot("slt", 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1);
        one_shot("sltu", 6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0);
        one_shot("sra", 6'h03, 32'h8000_0000, 32'd4, 5'd8, 32'hF800_0000);
        one_shot("badop", 6'h3F, 32'd123, 32'd456, 5'd9, 32'd0);

        cycle(1'b1, 6'h18, 32'hFFFF_FFFE, 32'd3, 5'd7, 1'b1);
        repeat (MUL_LAT) idle(1'b1);
        chk("mul_req", 32'(bus.cdb_req), 32'd1);
        chk("mul_tag", 32'(bus.cdb_tag), 32'd7);
        chk("mul_data", bus.cdb_data, 32'hFFFF_FFFA);
        idle(1'b1);

        cycle(1'b1, 6'h20, 32'd1, 32'd1, 5'd1, 1'b0);
        cycle(1'b1, 6'h20, 32'd2, 32'd2, 5'd2, 1'b0);
        chk("full_ready", 32'(bus.alu_ready), 32'd0);
        cycle(1'b1, 6'h20, 32'd3, 32'd3, 5'd12, 1'b0);
        chk("full_head", 32'(bus.cdb_tag), 32'd1);
        idle(1'b1);
        chk("drain_second", 32'(bus.cdb_tag), 32'd2);
        idle(1'b1);

        cycle(1'b1, 6'h20, 32'd10, 32'd0, 5'd10, 1'b0);
        cycle(1'b1, 6'h20, 32'd11, 32'd0, 5'd11, 1'b1);
        chk("swap_req", 32'(bus.cdb_req), 32'd1);
        chk("swap_tag", 32'(bus.cdb_tag), 32'd11);
        idle(1'b1);

        cycle(1'b1, 6'h20, 32'd1, 32'd4, 5'd13, 1'b0);
        cycle(1'b1, 6'h18, 32'd6, 32'd7, 5'd14, 1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req", 32'(bus.cdb_req), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_ready", 32'(bus.alu_ready), 32'd0);
        q.delete();
        mul_left  = 0;
        armed     = 0;
        last_tag  = 5'd0;
        last_data = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (MUL_LAT + 2) idle(1'b1);
        chk("post_rst_ready", 32'(bus.alu_ready), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            cycle($urandom_range(0, 9) < 7, ops[$urandom_range(0, 13)], a, b,
                  5'($urandom_range(0, 31)), $urandom_range(0, 9) < 6);
        end
        repeat (MUL_LAT + BUF_DEPTH + 2) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
